// File: rtl/node_inbound_rx.sv
// node_inbound_rx: receive side of the 8-bit node/router link.
// Reassembles 4-byte bursts into 32-bit packets and buffers them in a
// DEPTH-entry FIFO presented to the consumer.
//
// Optional build macro: DEST_CHECK_EN. When it is defined, completed packets
// whose dest field differs from NODEID are dropped and flagged on rx_error.
//
// Ports:
//   clock            system clock, rising edge
//   reset_n          asynchronous active-low reset
//   put_inbound      router presents a byte this cycle
//   payload_inbound  byte from router
//   free_inbound     registered; a full packet can be accepted
//   pkt_out          packet at FIFO head (combinational from storage)
//   pkt_out_avail    FIFO non-empty
//   pkt_out_ready    consumer takes the head when avail & ready
//   rx_error         one-cycle pulse on protocol violation or drop
//   occupancy        number of stored packets

package node_inbound_rx_pkg;
  typedef struct packed {
    logic [3:0]  src;
    logic [3:0]  dest;
    logic [23:0] data;
  } pkt_t;
endpackage

module node_inbound_rx
  import node_inbound_rx_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned NODEID = 0
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         put_inbound,
  input  logic [7:0]                   payload_inbound,
  output logic                         free_inbound,
  output logic [31:0]                  pkt_out,
  output logic                         pkt_out_avail,
  input  logic                         pkt_out_ready,
  output logic                         rx_error,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [7:0]      hdr_q, hdr_d;
  logic [15:0]     dat_q, dat_d;
  logic            busy_q, busy_d;
  logic            free_q, free_d;
  logic            err_q, err_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wptr_q, rptr_q;
  pkt_t            mem_q [DEPTH];

  logic            push_c, pop_c, dest_ok_c;
  pkt_t            wdata_c;

  // Destination filter; without it every completed packet is kept.
`ifdef DEST_CHECK_EN
  assign dest_ok_c = (hdr_q[3:0] == 4'(NODEID));
`else
  assign dest_ok_c = (hdr_q[3:0] == 4'(NODEID)) || 1'b1;
`endif

  assign wdata_c       = pkt_t'({hdr_q, dat_q, payload_inbound});
  assign pkt_out_avail = (count_q != '0);
  assign pop_c         = pkt_out_avail & pkt_out_ready;
  assign pkt_out       = mem_q[rptr_q];
  assign occupancy     = count_q;
  assign free_inbound  = free_q;
  assign rx_error      = err_q;

  // Burst reassembly FSM and reservation bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
    dat_d   = dat_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
    push_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (put_inbound) begin
          cnt_d = 2'd1;
          if (free_q) begin
            hdr_d   = payload_inbound;
            busy_d  = 1'b1;
            state_d = S_RECV;
          end else begin
            err_d   = 1'b1;
            state_d = S_DROP;
          end
        end
      end
      S_RECV: begin
        if (put_inbound) begin
          if (cnt_q == 2'd3) begin
            cnt_d   = 2'd0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
            if (dest_ok_c) push_c = 1'b1;
            else           err_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 2'd1;
            dat_d = {dat_q[7:0], payload_inbound};
          end
        end else begin
          // Sender stopped early: discard and free the reserved slot.
          cnt_d   = 2'd0;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DROP: begin
        if (put_inbound && (cnt_q != 2'd3)) begin
          cnt_d = cnt_q + 2'd1;
        end else begin
          cnt_d   = 2'd0;
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = 2'd0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    count_d = count_q + CW'(push_c) - CW'(pop_c);
    // An in-flight burst counts as an occupied slot.
    free_d  = (({1'b0, count_d} + (CW+1)'(busy_d)) < (CW+1)'(DEPTH));
  end

  // Control registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      hdr_q   <= 8'd0;
      dat_q   <= 16'd0;
      busy_q  <= 1'b0;
      free_q  <= 1'b1;
      err_q   <= 1'b0;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      dat_q   <= dat_d;
      busy_q  <= busy_d;
      free_q  <= free_d;
      err_q   <= err_d;
      count_q <= count_d;
      if (push_c) wptr_q <= wptr_q + PW'(1);
      if (pop_c)  rptr_q <= rptr_q + PW'(1);
    end
  end

  // Packet storage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_c) begin
      mem_q[wptr_q] <= wdata_c;
    end
  end

endmodule

// File: tb/tb_node_inbound_rx.sv
// Testbench for node_inbound_rx: table-driven vectors plus directed
// sequences for abort, simultaneous push/pop, destination handling and
// mid-burst reset.
module tb_node_inbound_rx;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        put_inbound = 1'b0;
  logic [7:0]  payload_inbound = 8'h00;
  logic        free_inbound;
  logic [31:0] pkt_out;
  logic        pkt_out_avail;
  logic        pkt_out_ready = 1'b0;
  logic        rx_error;
  logic [2:0]  occupancy;

  int n_chk  = 0;
  int n_fail = 0;

  node_inbound_rx #(.DEPTH(4), .NODEID(5)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .put_inbound     (put_inbound),
    .payload_inbound (payload_inbound),
    .free_inbound    (free_inbound),
    .pkt_out         (pkt_out),
    .pkt_out_avail   (pkt_out_avail),
    .pkt_out_ready   (pkt_out_ready),
    .rx_error        (rx_error),
    .occupancy       (occupancy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        put;
    logic [7:0]  pl;
    logic        rdy;
    logic        free;
    logic        avail;
    logic [31:0] pkt;
    logic        err;
    logic [2:0]  occ;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] P1 = 32'h15112233;
  localparam logic [31:0] P2 = 32'h35445566;
  localparam logic [31:0] P3 = 32'h75778899;
  localparam logic [31:0] P4 = 32'hA5AABBCC;

  task automatic add(input logic put, input logic [7:0] pl, input logic rdy,
                     input logic free, input logic avail, input logic [31:0] pkt,
                     input logic err, input logic [2:0] occ);
    vec_t v;
    v.put = put; v.pl = pl; v.rdy = rdy; v.free = free;
    v.avail = avail; v.pkt = pkt; v.err = err; v.occ = occ;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic put, input logic [7:0] pl, input logic rdy);
    put_inbound     = put;
    payload_inbound = pl;
    pkt_out_ready   = rdy;
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [31:0] p);
    cyc(1'b1, p[31:24], 1'b0);
    cyc(1'b1, p[23:16], 1'b0);
    cyc(1'b1, p[15:8],  1'b0);
    cyc(1'b1, p[7:0],   1'b0);
  endtask

  initial begin
    // Single packet, ready held high.
    add(1, 8'h25, 1, 1, 0, 0, 0, 0);
    add(1, 8'hAB, 1, 1, 0, 0, 0, 0);
    add(1, 8'hCD, 1, 1, 0, 0, 0, 0);
    add(1, 8'hEF, 1, 1, 1, 32'h25ABCDEF, 0, 1);
    add(0, 8'h00, 1, 1, 0, 0, 0, 0);
    // Fill with four back-to-back packets, consumer stalled.
    add(1, 8'h15, 0, 1, 0, 0,  0, 0);
    add(1, 8'h11, 0, 1, 0, 0,  0, 0);
    add(1, 8'h22, 0, 1, 0, 0,  0, 0);
    add(1, 8'h33, 0, 1, 1, P1, 0, 1);
    add(1, 8'h35, 0, 1, 1, P1, 0, 1);
    add(1, 8'h44, 0, 1, 1, P1, 0, 1);
    add(1, 8'h55, 0, 1, 1, P1, 0, 1);
    add(1, 8'h66, 0, 1, 1, P1, 0, 2);
    add(1, 8'h75, 0, 1, 1, P1, 0, 2);
    add(1, 8'h77, 0, 1, 1, P1, 0, 2);
    add(1, 8'h88, 0, 1, 1, P1, 0, 2);
    add(1, 8'h99, 0, 1, 1, P1, 0, 3);
    add(1, 8'hA5, 0, 0, 1, P1, 0, 3);
    add(1, 8'hAA, 0, 0, 1, P1, 0, 3);
    add(1, 8'hBB, 0, 0, 1, P1, 0, 3);
    add(1, 8'hCC, 0, 0, 1, P1, 0, 4);
    // Burst into a full FIFO: dropped with a single error pulse.
    add(1, 8'hE5, 0, 0, 1, P1, 1, 4);
    add(1, 8'hE6, 0, 0, 1, P1, 0, 4);
    add(1, 8'hE7, 0, 0, 1, P1, 0, 4);
    add(1, 8'hE8, 0, 0, 1, P1, 0, 4);
    add(0, 8'h00, 0, 0, 1, P1, 0, 4);
    // Drain in order.
    add(0, 8'h00, 1, 1, 1, P2, 0, 3);
    add(0, 8'h00, 1, 1, 1, P3, 0, 2);
    add(0, 8'h00, 1, 1, 1, P4, 0, 1);
    add(0, 8'h00, 1, 1, 0, 0,  0, 0);

    // Reset values while held in reset.
    repeat (2) @(posedge clock);
    #1;
    check("rst free",  32'(free_inbound),  32'd1);
    check("rst avail", 32'(pkt_out_avail), 32'd0);
    check("rst err",   32'(rx_error),      32'd0);
    check("rst occ",   32'(occupancy),     32'd0);
    check("rst pkt",   pkt_out,            32'd0);
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;

    foreach (vecs[i]) begin
      cyc(vecs[i].put, vecs[i].pl, vecs[i].rdy);
      check($sformatf("v%0d free", i),  32'(free_inbound),  32'(vecs[i].free));
      check($sformatf("v%0d avail", i), 32'(pkt_out_avail), 32'(vecs[i].avail));
      check($sformatf("v%0d err", i),   32'(rx_error),      32'(vecs[i].err));
      check($sformatf("v%0d occ", i),   32'(occupancy),     32'(vecs[i].occ));
      if (vecs[i].avail) check($sformatf("v%0d pkt", i), pkt_out, vecs[i].pkt);
    end

    // Abort after two bytes, then a clean packet.
    cyc(1, 8'h25, 0);
    cyc(1, 8'h01, 0);
    cyc(0, 8'h00, 0);
    check("abort err",   32'(rx_error),      32'd1);
    check("abort occ",   32'(occupancy),     32'd0);
    check("abort avail", 32'(pkt_out_avail), 32'd0);
    check("abort free",  32'(free_inbound),  32'd1);
    cyc(0, 8'h00, 0);
    check("abort err pulse", 32'(rx_error), 32'd0);
    send(32'h35123456);
    check("post-abort pkt", pkt_out,         32'h35123456);
    check("post-abort occ", 32'(occupancy),  32'd1);
    check("post-abort err", 32'(rx_error),   32'd0);
    cyc(0, 8'h00, 1);
    check("post-abort pop", 32'(occupancy),  32'd0);

    // Push and pop in the same cycle with two packets stored.
    send(32'h45A1A2A3);
    send(32'h55B1B2B3);
    check("pp occ2", 32'(occupancy), 32'd2);
    cyc(1, 8'h65, 0);
    cyc(1, 8'hC1, 0);
    cyc(1, 8'hC2, 0);
    cyc(1, 8'hC3, 1);
    check("pp occ",  32'(occupancy), 32'd2);
    check("pp head", pkt_out,        32'h55B1B2B3);
    check("pp free", 32'(free_inbound), 32'd1);
    cyc(0, 8'h00, 1);
    check("pp next", pkt_out,        32'h65C1C2C3);
    check("pp occ1", 32'(occupancy), 32'd1);
    cyc(0, 8'h00, 1);
    check("pp empty", 32'(pkt_out_avail), 32'd0);

    // Packet addressed to another node.
    send(32'h13010203);
`ifdef DEST_CHECK_EN
    check("dest occ", 32'(occupancy), 32'd0);
    check("dest err", 32'(rx_error),  32'd1);
`else
    check("dest occ", 32'(occupancy), 32'd1);
    check("dest err", 32'(rx_error),  32'd0);
    check("dest pkt", pkt_out,        32'h13010203);
    cyc(0, 8'h00, 1);
`endif
    cyc(0, 8'h00, 0);
    check("dest empty", 32'(occupancy), 32'd0);

    // Reset in the middle of a burst with one packet stored.
    send(32'h25000001);
    cyc(1, 8'h65, 0);
    cyc(1, 8'h0A, 0);
    check("mid occ pre", 32'(occupancy), 32'd1);
    reset_n = 1'b0;
    put_inbound = 1'b0;
    #1;
    check("mid rst free",  32'(free_inbound),  32'd1);
    check("mid rst avail", 32'(pkt_out_avail), 32'd0);
    check("mid rst occ",   32'(occupancy),     32'd0);
    check("mid rst pkt",   pkt_out,            32'd0);
    check("mid rst err",   32'(rx_error),      32'd0);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;
    cyc(1, 8'h0B, 0);
    cyc(1, 8'h0C, 0);
    cyc(0, 8'h00, 0);
    check("trail occ",   32'(occupancy),     32'd0);
    check("trail avail", 32'(pkt_out_avail), 32'd0);
    check("trail err",   32'(rx_error),      32'd1);
    cyc(0, 8'h00, 0);
    check("trail err pulse", 32'(rx_error),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
